bram_read_streamer: RTL



---
 rtl/bram_stream_pkg.sv | 35 +++
 rtl/bram_stream_fifo.sv | 67 ++++++
 rtl/bram_read_streamer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg: shared helpers, constants and the response record for the
// BRAM read streamer and its response FIFO.
package bram_stream_pkg;

  // Number of bits needed to hold 'depth'; called with RAM_DEPTH-1 so that
  // 1024 entries give a 10-bit BRAM address.
  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 0) begin
      d = d >> 1;
      n = n + 1;
    end
    return n;
  endfunction

  // Width of a counter that must reach fifo_depth inclusive.
  function automatic int credit_w(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int CREDIT_W           = credit_w(FIFO_DEPTH_DEFAULT);

  // Response record at the default BRAM width (18 bits).
  localparam int RSP_DATA_W = 18;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic                  is_wr;
  } bram_rsp_t;

endpackage

// File: rtl/bram_stream_fifo.sv
// bram_stream_fifo: synchronous response FIFO with a first-word-fall-through
// head, occupancy count, and push/pop allowed in the same cycle.
module bram_stream_fifo
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  localparam int CW   = credit_w(DEPTH)
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clka) begin
    if (rsta) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_read_streamer.sv
// bram_read_streamer: owns the port of a single-port read-first BRAM and turns
// valid/ready read/write requests into BRAM accesses, returning read data in
// issue order on a backpressured response channel.
// Optional build macro BRAM_STREAM_WR_RSP_EN: writes also return the prior
// contents as an in-order response tagged with rsp_wr_out=1.
module bram_read_streamer
  import bram_stream_pkg::*;
#(
  parameter int  RAM_WIDTH    = 18,
  parameter int  RAM_DEPTH    = 1024,
  parameter int  READ_LATENCY = 2,
  parameter int  FIFO_DEPTH   = 4,
  localparam int ADDR_W       = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic [ADDR_W-1:0]    rd_addr_in,
  input  logic                 rd_valid_in,
  output logic                 rd_ready_out,
  input  logic [ADDR_W-1:0]    wr_addr_in,
  input  logic [RAM_WIDTH-1:0] wr_data_in,
  input  logic                 wr_valid_in,
  output logic                 wr_ready_out,
  output logic [RAM_WIDTH-1:0] rsp_data_out,
  output logic                 rsp_wr_out,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic [ADDR_W-1:0]    ram_addr_out,
  output logic [RAM_WIDTH-1:0] ram_din_out,
  output logic                 ram_we_out,
  output logic                 ram_en_out,
  output logic                 ram_regce_out,
  input  logic [RAM_WIDTH-1:0] ram_dout_in
);

  // FIFO_DEPTH must be at least READ_LATENCY+1 to sustain one read per cycle.
  localparam int            CW      = credit_w(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CW-1:0]           credit_cnt;
  logic                    has_credit;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    issue;
  logic                    issue_wr;
  logic                    pop;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [READ_LATENCY-1:0] tag_pipe;
  logic                    fifo_push;
  logic [RAM_WIDTH:0]      fifo_din;
  logic [RAM_WIDTH:0]      fifo_head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [CW-1:0]           fifo_count;

  // A credit reserves a FIFO slot at issue time, so data returning from the
  // BRAM always has somewhere to land even under full backpressure.
  assign has_credit = (credit_cnt < DEPTH_C);

`ifdef BRAM_STREAM_WR_RSP_EN
  assign wr_ready_out = has_credit && !rsta;
  assign issue_wr     = wr_acc;
`else
  assign wr_ready_out = !rsta;
  assign issue_wr     = 1'b0;
`endif

  // Writes win arbitration; a read waits whenever a write is offered.
  assign rd_ready_out = !wr_valid_in && has_credit && !rsta;
  assign wr_acc       = wr_valid_in && wr_ready_out;
  assign rd_acc       = rd_valid_in && rd_ready_out;
  assign issue        = rd_acc || issue_wr;
  assign pop          = rsp_valid_out && rsp_ready_in;

  // BRAM port is driven combinationally; the BRAM registers its inputs.
  assign ram_en_out    = wr_acc || rd_acc;
  assign ram_we_out    = wr_acc;
  assign ram_addr_out  = wr_acc ? wr_addr_in : rd_addr_in;
  assign ram_din_out   = wr_data_in;
  assign ram_regce_out = 1'b1;

  // Credit counter: issued responses not yet popped by the consumer.
  always_ff @(posedge clka) begin
    if (rsta) begin
      credit_cnt <= '0;
    end else if (issue && !pop) begin
      credit_cnt <= credit_cnt + CW'(1);
    end else if (pop && !issue) begin
      credit_cnt <= credit_cnt - CW'(1);
    end
  end

  // Valid/tag pipe tracks the BRAM read latency; its tail marks ram_dout_in as ours.
  always_ff @(posedge clka) begin
    if (rsta) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= issue;
      tag_pipe[0] <= issue_wr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign fifo_push = vld_pipe[READ_LATENCY-1];
  assign fifo_din  = {tag_pipe[READ_LATENCY-1], ram_dout_in};

  bram_stream_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clka  (clka),
    .rsta  (rsta),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rsp_valid_out = !fifo_empty;
  assign rsp_data_out  = fifo_head[RAM_WIDTH-1:0];
  assign rsp_wr_out    = fifo_head[RAM_WIDTH];

  // Credits cover every buffered entry, so an overflow means broken accounting.
  assert property (@(posedge clka) disable iff (rsta) !(fifo_push && fifo_full))
    else $fatal(1, "bram_read_streamer: response FIFO overflow");

  assert property (@(posedge clka) disable iff (rsta) fifo_count <= credit_cnt)
    else $fatal(1, "bram_read_streamer: buffered responses exceed credits");

endmodule
